// File: rtl/lab3_sequence_generator_if.sv
// Request/response bundle between a pattern source and the serial sequence generator.
interface lab3_sequence_generator_if #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [3:0]       reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output x, valid, busy, done
  );
endinterface

// File: rtl/lab3_sequence_generator.sv
// Serial LSB-first pattern transmitter with back-to-back replay; all outputs
// are registered from the next-state decode so nothing flows input-to-output.
module lab3_sequence_generator #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input logic                      clk,
  input logic                      rst,
  lab3_sequence_generator_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pat_r, pat_s;
  logic [LW-1:0]    len_r, len_s;
  logic [3:0]       rep_r, rep_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic             x_r, x_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             legal_s;
  logic             last_s;

  assign legal_s = (bus.len != {LW{1'b0}}) && (bus.len <= LW'(WIDTH));
  assign last_s  = (LW'(idx_r) == (len_r - LW'(1)));

  // Next-state, capture and next-output decode
  always_comb begin
    state_s = state_r;
    pat_s   = pat_r;
    len_s   = len_r;
    rep_s   = rep_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (bus.start && legal_s) begin
          state_s = SEND;
          pat_s   = bus.pattern;
          len_s   = bus.len;
          rep_s   = bus.reps;
          idx_s   = {IW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (!last_s) begin
          idx_s = idx_r + IW'(1);
        end else if (rep_r != 4'd0) begin
          rep_s = rep_r - 4'd1;
          idx_s = {IW{1'b0}};
        end else begin
          state_s = DONE;
          idx_s   = {IW{1'b0}};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IW{1'b0}};
        rep_s   = 4'd0;
      end
    endcase

    // Outputs are a pure function of the state being entered, then registered
    if (state_s == SEND) begin
      x_s = pat_s[idx_s];
    end else begin
      x_s = 1'b0;
    end
    valid_s = (state_s == SEND);
    busy_s  = (state_s == SEND) || (state_s == DONE);
    done_s  = (state_s == DONE);
  end

  // State, captured request and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pat_r   <= {WIDTH{1'b0}};
      len_r   <= {LW{1'b0}};
      rep_r   <= 4'd0;
      idx_r   <= {IW{1'b0}};
      x_r     <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pat_r   <= pat_s;
      len_r   <= len_s;
      rep_r   <= rep_s;
      idx_r   <= idx_s;
      x_r     <= x_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.x     = x_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_lab3_sequence_generator.sv
// Randomized and directed bench for lab3_sequence_generator; expected outputs come
// from a queue of per-cycle output tuples built from each accepted request.
module tb_lab3_sequence_generator;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  lab3_sequence_generator_if #(.WIDTH(8), .LW(4)) bus ();

  lab3_sequence_generator #(.WIDTH(8), .LW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_cur;
  logic [3:0] obs;
  logic [15:0] xs;

  task automatic check_eq(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Tuple order {x, valid, busy, done}. Called at a falling edge.
  task automatic step(input string tag, input logic s, input logic [7:0] p,
                      input logic [3:0] l, input logic [3:0] r);
    bus.start   = s;
    bus.pattern = p;
    bus.len     = l;
    bus.reps    = r;
    if (exp_q.size() == 0 && s && l >= 4'd1 && l <= 4'd8) begin
      for (int t = 0; t <= int'(r); t++)
        for (int j = 0; j < int'(l); j++)
          exp_q.push_back({p[j], 3'b110});
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0000);
    end
    if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
    else exp_cur = 4'b0000;
    @(negedge clk);
    obs = {bus.x, bus.valid, bus.busy, bus.done};
    check_eq(tag, {12'd0, obs}, {12'd0, exp_cur});
  endtask

  task automatic async_reset(input string tag);
    #3 rst = 1'b0;
    #1 check_eq({tag, "_async"}, {12'd0, bus.x, bus.valid, bus.busy, bus.done}, 16'd0);
    exp_q.delete();
    bus.start = 1'b0;
    @(negedge clk);
    check_eq({tag, "_hold"}, {12'd0, bus.x, bus.valid, bus.busy, bus.done}, 16'd0);
    rst = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.pattern = 8'h00; bus.len = 4'd0; bus.reps = 4'd0;
    repeat (2) @(negedge clk);
    check_eq("reset", {12'd0, bus.x, bus.valid, bus.busy, bus.done}, 16'd0);
    rst = 1'b1;

    // Single 8-bit transfer
    xs = 16'd0;
    for (int i = 0; i < 8; i++) begin
      step("single", (i == 0), 8'h9C, 4'd8, 4'd0);
      xs[i] = obs[3];
    end
    check_eq("single_bits", xs, 16'h009C);
    step("single_done", 1'b0, 8'h00, 4'd0, 4'd0);
    check_eq("single_done_pulse", {12'd0, obs}, 16'h0003);
    step("single_idle", 1'b0, 8'h00, 4'd0, 4'd0);

    // Three-bit pattern sent three times back-to-back
    xs = 16'd0;
    for (int i = 0; i < 9; i++) begin
      step("repeat", (i == 0), 8'h05, 4'd3, 4'd2);
      xs[i] = obs[3];
      check_eq("repeat_valid", {15'd0, obs[2]}, 16'd1);
    end
    check_eq("repeat_bits", xs, 16'h016D);
    step("repeat_done", 1'b0, 8'h00, 4'd0, 4'd0);
    step("repeat_idle", 1'b0, 8'h00, 4'd0, 4'd0);

    // Illegal lengths are ignored
    step("illegal0", 1'b1, 8'hFF, 4'd0, 4'd3);
    step("illegal9", 1'b1, 8'hFF, 4'd9, 4'd0);
    step("illegal15", 1'b1, 8'hFF, 4'd15, 4'd1);
    step("illegal_idle", 1'b0, 8'h00, 4'd0, 4'd0);

    // New request during SEND must not disturb the running transfer
    xs = 16'd0;
    for (int i = 0; i < 8; i++) begin
      step("busy_req", (i == 0) || (i >= 2 && i < 7), (i == 0) ? 8'hA5 : 8'h5A,
           4'd8, (i == 0) ? 4'd0 : 4'd3);
      xs[i] = obs[3];
    end
    check_eq("busy_bits", xs, 16'h00A5);
    for (int i = 0; i < 4; i++) step("busy_tail", 1'b0, 8'h00, 4'd0, 4'd0);

    // Abort during bit 4, then recover
    for (int i = 0; i < 4; i++) step("abort_pre", (i == 0), 8'h3C, 4'd8, 4'd0);
    async_reset("abort");
    for (int i = 0; i < 3; i++) step("abort_quiet", 1'b0, 8'h00, 4'd0, 4'd0);
    step("recover", 1'b1, 8'hFF, 4'd2, 4'd0);
    for (int i = 0; i < 4; i++) step("recover", 1'b0, 8'h00, 4'd0, 4'd0);

    // Back-to-back single-bit transfers with start held high
    for (int i = 0; i < 12; i++) step("b2b", 1'b1, 8'h01, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) step("b2b_tail", 1'b0, 8'h00, 4'd0, 4'd0);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd_rst");
      end else begin
        logic [3:0] l;
        logic [3:0] r;
        l = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
        step("random", ($urandom_range(0, 3) == 0), 8'($urandom), l, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lab3_sequence_generator.md
# lab3_sequence_generator

Serial bit-pattern transmitter that drives the `x` input of the Lab3 sequence recognizers. It accepts a parallel pattern, a length and a repeat count, then shifts the pattern out LSB-first, one bit per clock. It can replay a pattern back-to-back a programmed number of times. It sits on the stimulus side of the recognizer and replaces hand-written `x` waveforms with a registered, cycle-exact source.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LW`, 4: width of `len`; must satisfy 2^LW > WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request to transmit; sampled on the rising edge.
- `pattern` input WIDTH: bits to send; `pattern[0]` is sent first.
- `len` input LW: number of pattern bits to send, legal range 1..WIDTH.
- `reps` input 4: additional repetitions; total transmissions = `reps`+1.
- `x` output 1: serial data bit; drives recognizer input `x`.
- `valid` output 1: high while `x` carries a pattern bit.
- `busy` output 1: high from the cycle after acceptance through the DONE cycle.
- `done` output 1: one-cycle pulse after the last bit.

## Operation
- FSM states and outputs:
  - IDLE: `x`=0, `valid`=0, `busy`=0, `done`=0.
  - SEND: `x`=current bit, `valid`=1, `busy`=1, `done`=0.
  - DONE: `x`=0, `valid`=0, `busy`=1, `done`=1.
- All outputs are registered (Moore). There is no combinational path from any input to any output.
- IDLE→SEND: `start`=1 and 1 ≤ `len` ≤ WIDTH at the edge. On that edge the block captures `pattern`, `len` and `reps` into internal registers and clears the bit index to 0.
- Illegal request: `start` with `len`=0 or `len`>WIDTH is ignored. The FSM stays in IDLE and no output changes.
- SEND, index < captured `len`-1: index increments.
- SEND, index = `len`-1 and repeat counter > 0: the repeat counter decrements and the index wraps to 0. The next cycle sends `pattern[0]` with no gap; `valid` stays high.
- SEND, index = `len`-1 and repeat counter = 0: go to DONE.
- DONE→IDLE unconditionally on the next edge.
- `start` is ignored in SEND and DONE.
- Input changes after acceptance have no effect; the block uses only the captured values.
- Reset (`rst`=0):
  - Immediately forces IDLE and clears `x`, `valid`, `busy`, `done`, the index and the repeat counter.
  - This holds in any state, including mid-SEND. No `done` is issued for an aborted transfer.
- Reset release: the first edge with `rst`=1 may accept `start`.

## Timing
- `start` is accepted at edge k. The first bit appears on `x` in cycle k+1.
- Bits occupy cycles k+1 .. k+N, where N = `len`×(`reps`+1).
- `done`=1 in cycle k+N+1. The FSM is back in IDLE in cycle k+N+2.
- Per-transfer occupancy is N+2 cycles. With `start` held high, consecutive acceptances are N+2 edges apart.
- Bit j of transmission r is `pattern[j]` in cycle k+1+r×`len`+j.
- The repeat counter is 4 bits, so the maximum is 16 transmissions. No counter wraps past zero.

## Test plan
1. Reset:
   - Stimulus: assert `rst`=0 mid-simulation, asynchronously between edges.
   - Response: `x`, `valid`, `busy`, `done` all go to 0 immediately without waiting for a clock.
2. Single transfer:
   - Stimulus: `pattern`=8'b1001_1100, `len`=8, `reps`=0, `start` pulsed at edge k.
   - Response: `x` = 0,0,1,1,1,0,0,1 in cycles k+1..k+8 with `valid`=1, `done`=1 in k+9, IDLE in k+10.
   - Loopback: feeding `x` into the recognizer yields its expected `z` trace.
3. Repeat:
   - Stimulus: `pattern`=8'b0000_0101, `len`=3, `reps`=2.
   - Response: `x` = 1,0,1,1,0,1,1,0,1 in nine contiguous cycles, `valid` never drops, single `done` in cycle k+10.
4. Illegal and busy requests:
   - Stimulus A: `start` with `len`=0. Response: no state change, all outputs stay 0.
   - Stimulus B: `start` re-asserted with a new `pattern` during SEND. Response: the original bits continue unchanged, and no second transfer follows.
5. Abort:
   - Stimulus: `rst`=0 during bit 4 of an 8-bit transfer.
   - Response: outputs clear immediately, and no `done` appears.
   - Recovery: after release, a new `start` with `pattern`=8'hFF, `len`=2 gives `x`=1,1 then `done`.
6. Back-to-back:
   - Stimulus: `len`=1, `pattern[0]`=1, `reps`=0, `start` held high.
   - Response: `x`=1 with `valid`=1 once every 3 cycles, `done` pulses 1 cycle after each bit, and IDLE lasts exactly one cycle between transfers.
